// File: rtl/store_narrowing_unit_if.sv
// Store request / data memory bundle for store_narrowing_unit.
//   req_valid/req_ready : store request handshake from the MEM stage
//   req_size            : 00 byte, 01 halfword, 10 word, 11 illegal
//   req_addr/req_data   : byte address and register value to store
//   mem_addr            : word address shared by the read and write strobes
//   mem_re/mem_rdata    : read strobe, data returned the following cycle
//   mem_we/mem_wdata    : write strobe with the full merged word
//   done/misaligned     : one-cycle completion / rejection pulses
// The slave modport is the unit's view; master is the requester+memory side.
interface store_narrowing_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_size;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_data;
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic                  mem_re;
  logic [31:0]           mem_rdata;
  logic                  mem_we;
  logic [31:0]           mem_wdata;
  logic                  done;
  logic                  misaligned;

  modport slave (
    input  req_valid, req_size, req_addr, req_data, mem_rdata,
    output req_ready, mem_addr, mem_re, mem_we, mem_wdata, done, misaligned
  );

  modport master (
    output req_valid, req_size, req_addr, req_data, mem_rdata,
    input  req_ready, mem_addr, mem_re, mem_we, mem_wdata, done, misaligned
  );
endinterface

// File: rtl/store_narrowing_unit.sv
// Narrows a 32-bit register value into a word-addressed data memory.
// Word stores write directly; byte and halfword stores read the old word,
// replace the addressed little-endian lane(s) and write the merged word back.
// Misaligned or illegal-size requests are rejected with a misaligned pulse
// and no memory access.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : store_narrowing_unit_if.slave (request, memory port, status)
module store_narrowing_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  store_narrowing_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t                state;
  logic [1:0]            cap_size;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [31:0]           cap_data;
  logic [31:0]           old_word;
  logic                  re_q;
  logic                  we_q;
  logic                  done_q;
  logic                  mis_q;

  // Illegal size, or a halfword/word whose address is not naturally aligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      2'b11:   bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Replace the addressed lane(s) of the old word; little-endian byte lanes.
  function automatic logic [31:0] merge_word(input logic [1:0]  size,
                                             input logic [1:0]  off,
                                             input logic [31:0] old,
                                             input logic [31:0] data);
    logic [31:0] w;
    w = old;
    case (size)
      2'b00:   w[{off, 3'b000} +: 8]     = data[7:0];
      2'b01:   w[{off[1], 4'b0000} +: 16] = data[15:0];
      default: w = data;
    endcase
    return w;
  endfunction

  // Strobes are registered alongside the state so each one is a clean
  // decode of the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cap_size <= '0;
      cap_addr <= '0;
      cap_data <= '0;
      old_word <= '0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      re_q   <= 1'b0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cap_size <= bus.req_size;
            cap_addr <= bus.req_addr;
            cap_data <= bus.req_data;
            if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
              state <= FAULT;
              mis_q <= 1'b1;
            end else if (bus.req_size == 2'b10) begin
              state  <= WRITE;
              we_q   <= 1'b1;
              done_q <= 1'b1;
            end else begin
              state <= READ;
              re_q  <= 1'b1;
            end
          end
        end
        READ: begin
          state <= WAIT;
        end
        // Read data is valid in the cycle after the read strobe.
        WAIT: begin
          old_word <= bus.mem_rdata;
          state    <= WRITE;
          we_q     <= 1'b1;
          done_q   <= 1'b1;
        end
        WRITE:   state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE) && reset;
  assign bus.mem_re     = re_q;
  assign bus.mem_we     = we_q;
  assign bus.done       = done_q;
  assign bus.misaligned = mis_q;
  assign bus.mem_addr   = cap_addr[ADDR_WIDTH-1:2];
  assign bus.mem_wdata  = merge_word(cap_size, cap_addr[1:0], old_word, cap_data);

endmodule

// File: tb/tb_store_narrowing_unit.sv
module tb_store_narrowing_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_narrowing_unit_if #(.ADDR_WIDTH(32)) bus();

  store_narrowing_unit #(.ADDR_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [16];
  logic [7:0]  ref_mem [64];
  int n_cmp = 0;
  int n_err = 0;
  int we_seen = 0;

  // Memory behind the unit: read data returned the cycle after mem_re.
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) begin
      mem[bus.mem_addr[3:0]] = bus.mem_wdata;
      we_seen++;
    end
    if (bus.mem_re === 1'b1)
      bus.mem_rdata <= mem[bus.mem_addr[3:0]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  task automatic preset_word(input int w, input logic [31:0] v);
    mem[w] = v;
    for (int b = 0; b < 4; b++) ref_mem[4*w+b] = v[8*b +: 8];
  endtask

  function automatic logic [31:0] strobes();
    return {27'd0, bus.mem_re, bus.mem_we, bus.done, bus.misaligned, bus.req_ready};
  endfunction

  // One request: update the byte-level reference, then check every cycle
  // from N+1 to N+4 against the latency rules.
  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int w;
    bit fault, sub, exp_re, exp_we, exp_mis, exp_rdy;
    logic [31:0] exp_w;
    w = int'(a[5:2]);
    fault = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    sub = !fault && (sz != 2'b10);
    if (!fault) begin
      if (sz == 2'b00) ref_mem[a[5:0]] = d[7:0];
      else if (sz == 2'b01) begin
        ref_mem[a[5:0]]   = d[7:0];
        ref_mem[a[5:0]+1] = d[15:8];
      end else
        for (int b = 0; b < 4; b++) ref_mem[a[5:0]+b] = d[8*b +: 8];
    end
    exp_w = ref_word(w);
    @(negedge clk);
    check("ready_idle", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_size  = sz;
    bus.req_addr  = a;
    bus.req_data  = d;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_size  = 2'($urandom);
    bus.req_addr  = $urandom;
    bus.req_data  = $urandom;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp_re  = sub && (k == 1);
      exp_we  = (!fault && !sub && k == 1) || (sub && k == 3);
      exp_mis = fault && (k == 1);
      exp_rdy = (k >= (sub ? 4 : 2));
      check($sformatf("strobes_c%0d", k), strobes(),
            {27'd0, exp_re, exp_we, exp_we, exp_mis, exp_rdy});
      if (exp_re || exp_we)
        check($sformatf("mem_addr_c%0d", k), {2'b00, bus.mem_addr}, 32'(w));
      if (exp_we)
        check($sformatf("mem_wdata_c%0d", k), bus.mem_wdata, exp_w);
    end
    check("mem_word", mem[w], exp_w);
  endtask

  initial begin
    logic [31:0] d0, d1, saved;
    int we_before;
    bus.req_valid = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 16; i++) preset_word(i, $urandom);

    // Reset: requests ignored, everything quiet, req_ready low.
    reset = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_size  = 2'b10;
    repeat (3) begin
      @(negedge clk);
      check("reset_strobes", strobes(), 32'd0);
    end
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_strobes", strobes(), 32'd1);
    check("post_reset_addr", {2'b00, bus.mem_addr}, 32'd0);
    check("post_reset_wdata", bus.mem_wdata, 32'd0);
    check("reset_no_write", 32'(we_seen), 32'd0);

    // Directed cases.
    do_store(2'b10, 32'h0000_0010, 32'hDEAD_BEEF);
    preset_word(4, 32'h1122_3344);
    do_store(2'b00, 32'h0000_0013, 32'h1234_56AB);
    check("byte_merge_value", mem[4], 32'hAB22_3344);
    preset_word(8, 32'hAAAA_BBBB);
    do_store(2'b01, 32'h0000_0022, 32'hFFFF_8001);
    check("half_merge_value", mem[8], 32'h8001_BBBB);
    do_store(2'b01, 32'h0000_0001, $urandom);
    do_store(2'b10, 32'h0000_0002, $urandom);
    do_store(2'b11, 32'h0000_0000, $urandom);

    // Back-to-back word stores with req_valid held.
    d0 = $urandom;
    d1 = $urandom;
    for (int b = 0; b < 4; b++) begin
      ref_mem[b]   = d0[8*b +: 8];
      ref_mem[4+b] = d1[8*b +: 8];
    end
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h0;
    bus.req_data  = d0;
    @(posedge clk);
    #1;
    bus.req_addr = 32'h4;
    bus.req_data = d1;
    @(negedge clk);
    check("b2b_first_we", strobes(), 32'b01100);
    check("b2b_first_addr", {2'b00, bus.mem_addr}, 32'd0);
    check("b2b_first_wdata", bus.mem_wdata, d0);
    @(negedge clk);
    check("b2b_gap", strobes(), 32'b00001);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("b2b_second_we", strobes(), 32'b01100);
    check("b2b_second_addr", {2'b00, bus.mem_addr}, 32'd1);
    check("b2b_second_wdata", bus.mem_wdata, d1);
    @(negedge clk);
    check("b2b_idle", strobes(), 32'b00001);
    check("b2b_mem0", mem[0], ref_word(0));
    check("b2b_mem1", mem[1], ref_word(1));

    // Reset during WAIT aborts a byte store.
    saved = mem[1];
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h5;
    bus.req_data  = $urandom;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("abort_read", strobes(), 32'b10000);
    @(negedge clk);
    we_before = we_seen;
    reset = 1'b0;
    @(negedge clk);
    check("abort_strobes", strobes(), 32'd0);
    check("abort_addr", {2'b00, bus.mem_addr}, 32'd0);
    check("abort_wdata", bus.mem_wdata, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_ready", strobes(), 32'd1);
    check("abort_no_we", 32'(we_seen - we_before), 32'd0);
    check("abort_mem", mem[1], saved);

    // Randomized requests against the byte-level reference memory.
    for (int i = 0; i < 40; i++)
      do_store(2'($urandom), 32'($urandom_range(0, 63)), $urandom);
    for (int i = 0; i < 16; i++)
      check($sformatf("final_mem%0d", i), mem[i], ref_word(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
